// File: rtl/hamming_rx_ctrl_if.sv
// Handshake bundle for hamming_rx_ctrl: serial bit input, result output and
// error statistics. The DUT uses the slave view; the driver/consumer uses master.
interface hamming_rx_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic [0:3]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             err_flag;
  logic [2:0]       err_pos;
  logic [CNT_W-1:0] err_count;
  logic             clr_count;
  logic             frame_abort;
  logic             busy;

  modport slave (
    input  ser_in, ser_valid, out_ready, clr_count,
    output ser_ready, out_data, out_valid, err_flag, err_pos, err_count, frame_abort, busy
  );

  modport master (
    output ser_in, ser_valid, out_ready, clr_count,
    input  ser_ready, out_data, out_valid, err_flag, err_pos, err_count, frame_abort, busy
  );
endinterface

// File: rtl/hamming_rx_ctrl.sv
// Serial Hamming(7,4) receiver: assembles 7-bit codewords, corrects single-bit
// errors, tracks error statistics and presents the nibble over valid/ready.
module hamming_rx_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned GAP_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_rx_ctrl_if.slave      bus
);

  localparam logic [7:0] GapMax = 8'(GAP_MAX);

  typedef enum logic [1:0] {StIdle, StShift, StDecode, StHold} state_e;

  state_e           state_q, state_d;
  logic [6:0]       sh_q, sh_d;             // sh_q[i] holds codeword position i+1
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [0:3]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_flag_q, err_flag_d;
  logic [2:0]       err_pos_q, err_pos_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             frame_abort_q, frame_abort_d;

  logic       ser_ready;
  logic       accept;
  logic [2:0] syn;
  logic [6:0] fixed;
  logic [0:3] dec_data;

  assign ser_ready = (state_q == StIdle) || (state_q == StShift);
  assign accept    = bus.ser_valid && ser_ready;

  // Syndrome and single-bit correction of the assembled codeword
  always_comb begin
    syn[0] = sh_q[0] ^ sh_q[2] ^ sh_q[4] ^ sh_q[6];
    syn[1] = sh_q[1] ^ sh_q[2] ^ sh_q[5] ^ sh_q[6];
    syn[2] = sh_q[3] ^ sh_q[4] ^ sh_q[5] ^ sh_q[6];
    fixed  = sh_q;
    if (syn != 3'd0) begin
      fixed = sh_q ^ (7'b1 << (syn - 3'd1));
    end
    dec_data = {fixed[2], fixed[4], fixed[5], fixed[6]};
  end

  // Next-state and datapath updates for the receive sequencer
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    err_flag_d    = err_flag_q;
    err_pos_d     = err_pos_q;
    err_count_d   = err_count_q;
    frame_abort_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sh_d      = {6'b0, bus.ser_in};
          bit_cnt_d = 3'd1;
          gap_cnt_d = 8'd0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (accept) begin
          sh_d[bit_cnt_q] = bus.ser_in;
          bit_cnt_d       = bit_cnt_q + 3'd1;
          gap_cnt_d       = 8'd0;
          if (bit_cnt_q == 3'd6) begin
            bit_cnt_d = 3'd0;
            state_d   = StDecode;
          end
        end else if (gap_cnt_q + 8'd1 == GapMax) begin
          // Link went quiet mid-frame: drop the partial codeword
          frame_abort_d = 1'b1;
          bit_cnt_d     = 3'd0;
          gap_cnt_d     = 8'd0;
          state_d       = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      StDecode: begin
        out_data_d  = dec_data;
        err_pos_d   = syn;
        err_flag_d  = (syn != 3'd0);
        out_valid_d = 1'b1;
        if ((syn != 3'd0) && (err_count_q != '1)) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
        state_d = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear has priority over a coincident increment
    if (bus.clr_count) begin
      err_count_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sh_q          <= 7'd0;
      bit_cnt_q     <= 3'd0;
      gap_cnt_q     <= 8'd0;
      out_data_q    <= 4'd0;
      out_valid_q   <= 1'b0;
      err_flag_q    <= 1'b0;
      err_pos_q     <= 3'd0;
      err_count_q   <= '0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      err_flag_q    <= err_flag_d;
      err_pos_q     <= err_pos_d;
      err_count_q   <= err_count_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign bus.ser_ready   = ser_ready;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.err_flag    = err_flag_q;
  assign bus.err_pos     = err_pos_q;
  assign bus.err_count   = err_count_q;
  assign bus.frame_abort = frame_abort_q;
  assign bus.busy        = (state_q != StIdle);

endmodule
